multicycle_control: RTL
=======================

# multicycle_control

Main sequencing FSM for the multi-cycle RV32I datapath. It replaces the single-cycle opcode decoder when instruction and data share one memory port. Each instruction runs as a sequence of states: fetch, decode, execute, memory and writeback. The block drives per-state mux selects, write enables and the ALU operation class, and holds in any memory state until the shared memory handshakes.

## Interface
Parameters:
- none (RV32I base opcodes are fixed in the block)

Ports (clock and reset first):
- clk  input  1  single system clock; all state updates on rising edge
- rstn  input  1  asynchronous, active-low reset
- opcode  input  7  instruction[6:0] taken from the datapath instruction register (IR)
- mem_ready  input  1  shared memory has completed the current request this cycle
- branch_taken  input  1  branch condition result from the branch comparator, valid in BRANCH
- mem_req  output  1  memory request; held high until mem_ready
- mem_we  output  1  memory write (store)
- iord  output  1  memory address select: 0 = PC, 1 = ALU-out register
- ir_write  output  1  load IR and old_pc
- pc_write  output  1  load PC from the result mux
- reg_write  output  1  register-file write enable
- alu_src_a  output  2  ALU A select: 00 = PC, 01 = old_pc, 10 = rs1
- alu_src_b  output  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4
- alu_op  output  2  ALU class: 00 = add, 01 = branch compare/sub, 10 = R-type funct, 11 = I-type funct
- result_src  output  2  result mux: 00 = ALU-out register, 01 = memory-data register, 10 = live ALU result
- retire  output  1  one-cycle pulse on the last cycle of each completed instruction
- trap  output  1  high in TRAP (illegal opcode)
- state  output  4  current state encoding, for debug

## Operation
State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, TRAP=15. Codes 12–14 are unused.

Any output not listed for a state is 0.

- **FETCH**
  - Outputs: mem_req=1, iord=0, a=PC, b=4, op=00, result_src=10.
  - ir_write = pc_write = mem_ready.
  - Next: DECODE on mem_ready, otherwise stay.
- **DECODE**
  - Outputs: a=old_pc, b=imm, op=00. This precomputes the branch/JAL target into the ALU-out register.
  - Next by opcode:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 or 0100011 → MEMADR
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - any other opcode → TRAP
- **MEMADR**
  - Outputs: a=rs1, b=imm, op=00.
  - Next: MEMRD if opcode is a load, MEMWR if a store.
- **MEMRD**
  - Outputs: mem_req=1, iord=1.
  - Next: MEMWB on mem_ready.
- **MEMWB**
  - Outputs: result_src=01, reg_write=1, retire=1.
  - Next: FETCH.
- **MEMWR**
  - Outputs: mem_req=1, mem_we=1, iord=1.
  - On mem_ready: retire=1 and go to FETCH.
- **EXEC_R**
  - Outputs: a=rs1, b=rs2, op=10.
  - Next: ALUWB.
- **EXEC_I**
  - Outputs: a=rs1, b=imm, op=11.
  - Next: ALUWB.
- **ALUWB**
  - Outputs: result_src=00, reg_write=1, retire=1.
  - Next: FETCH.
- **BRANCH**
  - Outputs: a=rs1, b=rs2, op=01, result_src=00, pc_write=branch_taken, retire=1.
  - Next: FETCH.
- **JALR**
  - Outputs: a=rs1, b=imm, op=00. This writes the rs1+imm target into the ALU-out register.
  - Next: JAL.
- **JAL**
  - Outputs: result_src=00, pc_write=1 (PC ← target), a=old_pc, b=4, op=00 (link value captured into ALU-out).
  - Next: ALUWB, which writes the link value to rd.
- **TRAP**
  - Outputs: all enables 0, trap=1.
  - Stays in TRAP until reset.

Unused state codes go to TRAP on the next cycle.

## Timing
- Reset:
  - rstn low forces state=FETCH immediately (asynchronously).
  - Outputs are therefore the FETCH values (mem_req=1, iord=0) while in reset. pc_write and ir_write stay 0 unless mem_ready is high.
  - Release of rstn mid-operation restarts at FETCH; no partial instruction resumes.
- Output decode:
  - All outputs decode combinationally from state (Moore).
  - Exceptions: ir_write, pc_write (FETCH, BRANCH) and retire (MEMWR) also depend on mem_ready or branch_taken in the same cycle (Mealy).
- Memory handshake:
  - mem_req stays asserted and iord/mem_we stay stable every cycle until mem_ready.
  - mem_ready outside FETCH/MEMRD/MEMWR is ignored.
  - mem_ready in the first request cycle gives zero wait states.
- Latency with zero wait states:
  - R/I-ALU: 4 cycles
  - load: 5
  - store: 4
  - branch: 3
  - JAL: 4
  - JALR: 5
  - Each wait state adds 1 cycle.
- opcode must stay stable from DECODE through the end of the instruction (IR is written only in FETCH).

## Test plan
- Reset, then opcode=0110011 with mem_ready=1 → states 0,1,6,8,0. reg_write=1 only in state 8, retire pulses once, alu_op=10 in state 6.
- Load (0000011) with mem_ready held low 3 cycles in MEMRD → mem_req=1 and iord=1 for 4 cycles, then MEMWB with result_src=01 and reg_write=1; total 8 cycles.
- Branch (1100011) with branch_taken=1, then repeated with 0 → pc_write=1 in BRANCH for the first, 0 for the second. Both return to FETCH after 3 cycles.
- JALR (1100111) → sequence 0,1,11,10,8. pc_write=1 in JAL, reg_write=1 in ALUWB.
- Illegal opcode 0000000 → TRAP after DECODE, trap=1, mem_req=0 indefinitely. rstn low then high → FETCH.
- rstn asserted during MEMWR wait → state=0 without waiting for a clock edge, and no retire pulse.

Source files
------------

// File: rtl/multicycle_control.sv
// Main sequencing FSM for the multi-cycle RV32I datapath with a shared memory port.
// Moore decode from state, except ir_write/pc_write/retire, which also follow the handshake or branch result.
`timescale 1ns/1ps
module multicycle_control (
   input  logic       clk,
   input  logic       rstn,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   input  logic       branch_taken,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] result_src,
   output logic       retire,
   output logic       trap,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC_R = 4'd6,
      S_EXEC_I = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_JAL    = 4'd10,
      S_JALR   = 4'd11,
      S_TRAP   = 4'd15
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [1:0] A_PC    = 2'b00;
   localparam logic [1:0] A_OLDPC = 2'b01;
   localparam logic [1:0] A_RS1   = 2'b10;
   localparam logic [1:0] B_RS2   = 2'b00;
   localparam logic [1:0] B_IMM   = 2'b01;
   localparam logic [1:0] B_FOUR  = 2'b10;

   state_t state_q, state_d;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   assign state = state_q;

   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = A_PC;
      alu_src_b  = B_RS2;
      alu_op     = 2'b00;
      result_src = 2'b00;
      retire     = 1'b0;
      trap       = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_a  = A_PC;
            alu_src_b  = B_FOUR;
            result_src = 2'b10;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            // Branch/JAL target is precomputed here into the ALU-out register.
            alu_src_a = A_OLDPC;
            alu_src_b = B_IMM;
            case (opcode)
               OP_R:              state_d = S_EXEC_R;
               OP_I:              state_d = S_EXEC_I;
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR;
               default:           state_d = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = A_RS1;
            alu_src_b = B_IMM;
            if (opcode == OP_LOAD)       state_d = S_MEMRD;
            else if (opcode == OP_STORE) state_d = S_MEMWR;
            else                         state_d = S_TRAP;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            iord    = 1'b1;
            retire  = mem_ready;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXEC_R: begin
            alu_src_a = A_RS1;
            alu_src_b = B_RS2;
            alu_op    = 2'b10;
            state_d   = S_ALUWB;
         end
         S_EXEC_I: begin
            alu_src_a = A_RS1;
            alu_src_b = B_IMM;
            alu_op    = 2'b11;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            result_src = 2'b00;
            reg_write  = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a  = A_RS1;
            alu_src_b  = B_RS2;
            alu_op     = 2'b01;
            result_src = 2'b00;
            pc_write   = branch_taken;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_JALR: begin
            alu_src_a = A_RS1;
            alu_src_b = B_IMM;
            state_d   = S_JAL;
         end
         S_JAL: begin
            // PC takes the stored target while the ALU captures the link value old_pc+4.
            result_src = 2'b00;
            pc_write   = 1'b1;
            alu_src_a  = A_OLDPC;
            alu_src_b  = B_FOUR;
            state_d    = S_ALUWB;
         end
         S_TRAP: begin
            trap    = 1'b1;
            state_d = S_TRAP;
         end
         default: state_d = S_TRAP;
      endcase
   end

endmodule
